// File: rtl/mem_arbiter.sv
// Three-way arbiter (fetch, load, store) in front of the byte-serial memory controller.
// Store-first priority with a fetch starvation guard; flush cancels speculative reads.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_width,
  output logic        ld_done,
  output logic [31:0] ld_data,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [2:0]  st_width,
  input  logic [31:0] st_data,
  output logic        st_done,
  output logic        mc_enable,
  output logic        mc_write,
  output logic [2:0]  mc_width,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_wdata,
  input  logic [31:0] mc_rdata,
  input  logic        mc_ok
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_LD, OWN_ST} owner_t;

  state_t          state_reg;
  owner_t          owner_reg;
  logic [CW-1:0]   starve_cnt_reg;

  logic force_if, grant_if, grant_ld, grant_st;

  function automatic logic [31:0] mask_bytes(input logic [31:0] d, input logic [2:0] w);
    case (w)
      3'd1:    return {24'h0, d[7:0]};
      3'd2:    return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Flush blocks both reads in IDLE, but a pending store is still granted.
  always_comb begin
    force_if = (starve_cnt_reg == CW'(STARVE_LIMIT)) && if_req && !flush;
    grant_if = 1'b0;
    grant_ld = 1'b0;
    grant_st = 1'b0;
    if (force_if)             grant_if = 1'b1;
    else if (st_req)          grant_st = 1'b1;
    else if (!flush && ld_req) grant_ld = 1'b1;
    else if (!flush && if_req) grant_if = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_IF;
      starve_cnt_reg <= '0;
      if_done        <= 1'b0;
      ld_done        <= 1'b0;
      st_done        <= 1'b0;
      if_data        <= 32'h0;
      ld_data        <= 32'h0;
      mc_enable      <= 1'b0;
      mc_write       <= 1'b0;
      mc_width       <= 3'd0;
      mc_addr        <= 32'h0;
      mc_wdata       <= 32'h0;
    end else if (rdy) begin
      if_done <= 1'b0;
      ld_done <= 1'b0;
      st_done <= 1'b0;
      if (!if_req) starve_cnt_reg <= '0;

      case (state_reg)
        IDLE: begin
          if (grant_if) begin
            owner_reg <= OWN_IF;
            mc_addr   <= if_addr;
            mc_width  <= 3'd4;
            mc_write  <= 1'b0;
            mc_wdata  <= 32'h0;
          end else if (grant_ld) begin
            owner_reg <= OWN_LD;
            mc_addr   <= ld_addr;
            mc_width  <= ld_width;
            mc_write  <= 1'b0;
            mc_wdata  <= 32'h0;
          end else if (grant_st) begin
            owner_reg <= OWN_ST;
            mc_addr   <= st_addr;
            mc_width  <= st_width;
            mc_write  <= 1'b1;
            mc_wdata  <= st_data;
          end
          if (grant_if || grant_ld || grant_st) begin
            mc_enable <= 1'b1;
            state_reg <= BUSY;
          end
          if (grant_if)
            starve_cnt_reg <= '0;
          else if ((grant_ld || grant_st) && if_req && starve_cnt_reg != CW'(STARVE_LIMIT))
            starve_cnt_reg <= starve_cnt_reg + CW'(1);
        end

        BUSY: begin
          // A flushed read is abandoned even if the controller answers this same cycle.
          if (flush && owner_reg != OWN_ST) begin
            mc_enable <= 1'b0;
            state_reg <= TURN;
          end else if (mc_ok) begin
            case (owner_reg)
              OWN_IF: begin
                if_done <= 1'b1;
                if_data <= mc_rdata;
              end
              OWN_LD: begin
                ld_done <= 1'b1;
                ld_data <= mask_bytes(mc_rdata, mc_width);
              end
              default: st_done <= 1'b1;
            endcase
            mc_enable <= 1'b0;
            state_reg <= TURN;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table for single transactions plus
// hand-written priority, starvation, flush, rdy and reset sequences; dones go through a scoreboard.
module tb_mem_arbiter;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        if_req, ld_req, st_req;
  logic [31:0] if_addr, ld_addr, st_addr, st_data;
  logic [2:0]  ld_width, st_width;
  logic        if_done, ld_done, st_done;
  logic [31:0] if_data, ld_data;
  logic        mc_enable, mc_write, mc_ok;
  logic [2:0]  mc_width;
  logic [31:0] mc_addr, mc_wdata, mc_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_width(ld_width), .ld_done(ld_done), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_width(st_width), .st_data(st_data), .st_done(st_done),
    .mc_enable(mc_enable), .mc_write(mc_write), .mc_width(mc_width), .mc_addr(mc_addr),
    .mc_wdata(mc_wdata), .mc_rdata(mc_rdata), .mc_ok(mc_ok)
  );

  typedef struct {
    logic [2:0]  mask;   // {st, ld, if}
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int          who;    // 0 IF, 1 LD, 2 ST
    logic [31:0] addr;
    logic [2:0]  width;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic [2:0]  exp_width;
    logic [31:0] exp_data;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[7];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_ld = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!mc_enable && n < 20);
    if (!mc_enable) begin
      checks++;
      failures++;
      $display("FAIL grant_timeout actual=no_grant required=grant_within_20");
    end
  endtask

  task automatic expect_done(input logic [2:0] m, input logic [31:0] d);
    exp_t e;
    e.mask = m;
    e.data = d;
    exp_q.push_back(e);
    if (m == 3'b010) last_ld = d;
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (if_done || ld_done || st_done) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done actual=%b required=none", {st_done, ld_done, if_done});
      end else begin
        e = exp_q.pop_front();
        $display("done {st,ld,if}=%b if_data=0x%08h ld_data=0x%08h", {st_done, ld_done, if_done}, if_data, ld_data);
        if ({st_done, ld_done, if_done} !== e.mask) begin
          failures++;
          $display("FAIL done_owner actual=%b required=%b", {st_done, ld_done, if_done}, e.mask);
        end else if (e.mask[0] && if_data !== e.data) begin
          failures++;
          $display("FAIL if_data actual=0x%08h required=0x%08h", if_data, e.data);
        end else if (e.mask[1] && ld_data !== e.data) begin
          failures++;
          $display("FAIL ld_data actual=0x%08h required=0x%08h", ld_data, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t v;
    int   n;
    logic exp_if;

    vecs[0] = '{0, 32'h100, 3'd0, 32'h0,        32'hDEADBEEF, 5, 3'd4, 32'hDEADBEEF};
    vecs[1] = '{1, 32'h200, 3'd1, 32'h0,        32'hA5A5A5C3, 2, 3'd1, 32'h000000C3};
    vecs[2] = '{1, 32'h204, 3'd2, 32'h0,        32'h11223344, 0, 3'd2, 32'h00003344};
    vecs[3] = '{1, 32'h208, 3'd4, 32'h0,        32'hCAFEF00D, 1, 3'd4, 32'hCAFEF00D};
    vecs[4] = '{2, 32'h300, 3'd1, 32'hAABBCCDD, 32'h0,        3, 3'd1, 32'h0};
    vecs[5] = '{2, 32'h304, 3'd4, 32'h01020304, 32'h0,        0, 3'd4, 32'h0};
    vecs[6] = '{0, 32'h104, 3'd0, 32'h0,        32'h00000013, 1, 3'd4, 32'h00000013};

    rst = 1'b1; rdy = 1'b1; flush = 1'b0; mc_ok = 1'b0; mc_rdata = 32'h0;
    if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    if_addr = 32'h0; ld_addr = 32'h0; st_addr = 32'h0; st_data = 32'h0;
    ld_width = 3'd0; st_width = 3'd0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check1("rst_mc_enable", mc_enable, 1'b0);
    check1("rst_mc_write", mc_write, 1'b0);
    check("rst_mc_width", 32'(mc_width), 32'h0);
    check("rst_mc_addr", mc_addr, 32'h0);
    check("rst_mc_wdata", mc_wdata, 32'h0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_ld_data", ld_data, 32'h0);

    // Single-requester transactions from the table.
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      case (v.who)
        0: begin if_req = 1'b1; if_addr = v.addr; end
        1: begin ld_req = 1'b1; ld_addr = v.addr; ld_width = v.width; end
        default: begin st_req = 1'b1; st_addr = v.addr; st_width = v.width; st_data = v.wdata; end
      endcase
      step();
      $display("vec %0d who=%0d mc_addr=0x%08h mc_width=%0d mc_write=%b", i, v.who, mc_addr, mc_width, mc_write);
      check1("vec_grant_en", mc_enable, 1'b1);
      check("vec_addr", mc_addr, v.addr);
      check("vec_width", 32'(mc_width), 32'(v.exp_width));
      check1("vec_write", mc_write, v.who == 2);
      if (v.who == 2) check("vec_wdata", mc_wdata, v.wdata);
      repeat (v.delay) step();
      check1("vec_hold_en", mc_enable, 1'b1);
      check("vec_hold_addr", mc_addr, v.addr);
      mc_ok = 1'b1;
      mc_rdata = v.rdata;
      expect_done(3'b001 << v.who, v.exp_data);
      step();
      mc_ok = 1'b0; if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
      check1("vec_done_en_low", mc_enable, 1'b0);
      step();
      check1("vec_turn_en_low", mc_enable, 1'b0);
    end

    // Priority: all three rise together; expect ST, LD, IF with a 2-cycle gap.
    st_req = 1'b1; st_addr = 32'h310; st_width = 3'd4; st_data = 32'h55;
    ld_req = 1'b1; ld_addr = 32'h210; ld_width = 3'd4;
    if_req = 1'b1; if_addr = 32'h110;
    wait_grant(n);
    check("prio_latency", n, 1);
    check("prio_first_st", mc_addr, 32'h310);
    check1("prio_first_write", mc_write, 1'b1);
    mc_ok = 1'b1; expect_done(3'b100, 32'h0);
    step();
    mc_ok = 1'b0; st_req = 1'b0;
    wait_grant(n);
    check("prio_gap_ld", n, 2);
    check("prio_second_ld", mc_addr, 32'h210);
    mc_ok = 1'b1; mc_rdata = 32'h77; expect_done(3'b010, 32'h77);
    step();
    mc_ok = 1'b0; ld_req = 1'b0;
    wait_grant(n);
    check("prio_gap_if", n, 2);
    check("prio_third_if", mc_addr, 32'h110);
    mc_ok = 1'b1; mc_rdata = 32'h88; expect_done(3'b001, 32'h88);
    step();
    mc_ok = 1'b0; if_req = 1'b0;
    step(); step();

    // Starvation: IF forced after every 8 LD grants, twice in a row.
    if_req = 1'b1; if_addr = 32'h400;
    ld_req = 1'b1; ld_addr = 32'h500; ld_width = 3'd4;
    for (int g = 0; g < 18; g++) begin
      wait_grant(n);
      exp_if = (g % 9) == 8;
      $display("starve grant %0d mc_addr=0x%08h", g, mc_addr);
      check("starve_owner", mc_addr, exp_if ? 32'h400 : 32'h500);
      mc_ok = 1'b1;
      mc_rdata = g;
      expect_done(exp_if ? 3'b001 : 3'b010, g);
      step();
      mc_ok = 1'b0;
    end
    if_req = 1'b0; ld_req = 1'b0;
    step(); step();

    // Flush in IDLE blocks the load; flush mid-read discards a coincident ok.
    ld_req = 1'b1; ld_addr = 32'h600; ld_width = 3'd1; flush = 1'b1;
    step();
    check1("flush_idle_no_ld", mc_enable, 1'b0);
    flush = 1'b0;
    step();
    check1("flush_rd_grant", mc_enable, 1'b1);
    check("flush_rd_width", 32'(mc_width), 32'd1);
    step();
    flush = 1'b1; mc_ok = 1'b1; mc_rdata = 32'hFFFFFFAB;
    step();
    check1("flush_rd_en_low", mc_enable, 1'b0);
    flush = 1'b0; mc_ok = 1'b0; ld_req = 1'b0;
    step();
    check1("flush_rd_turn", mc_enable, 1'b0);
    check("flush_rd_ld_held", ld_data, last_ld);
    step();
    check1("flush_rd_idle", mc_enable, 1'b0);

    // Flush does not block or cancel a store.
    st_req = 1'b1; st_addr = 32'h700; st_width = 3'd2; st_data = 32'h12345678;
    ld_req = 1'b1; ld_addr = 32'h610; flush = 1'b1;
    step();
    check1("flush_st_grant", mc_enable, 1'b1);
    check1("flush_st_write", mc_write, 1'b1);
    check("flush_st_addr", mc_addr, 32'h700);
    check("flush_st_width", 32'(mc_width), 32'd2);
    step();
    check1("flush_st_hold", mc_enable, 1'b1);
    check("flush_st_wdata", mc_wdata, 32'h12345678);
    flush = 1'b0; ld_req = 1'b0;
    mc_ok = 1'b1; expect_done(3'b100, 32'h0);
    step();
    mc_ok = 1'b0; st_req = 1'b0;
    check1("flush_st_done_en_low", mc_enable, 1'b0);
    step(); step();

    // rdy low freezes BUSY even with ok held; completes once rdy returns.
    ld_req = 1'b1; ld_addr = 32'h800; ld_width = 3'd2;
    wait_grant(n);
    rdy = 1'b0; mc_ok = 1'b1; mc_rdata = 32'h9999AAAA;
    for (int k = 0; k < 3; k++) begin
      step();
      check1("rdy_frozen_en", mc_enable, 1'b1);
      check("rdy_frozen_addr", mc_addr, 32'h800);
      check("rdy_frozen_width", 32'(mc_width), 32'd2);
    end
    rdy = 1'b1; expect_done(3'b010, 32'h0000AAAA);
    step();
    mc_ok = 1'b0; ld_req = 1'b0;
    check1("rdy_done_en_low", mc_enable, 1'b0);
    step(); step();

    // Reset mid-BUSY: all outputs cleared, no done even with ok present.
    if_req = 1'b1; if_addr = 32'h900;
    wait_grant(n);
    rst = 1'b1; mc_ok = 1'b1; mc_rdata = 32'h1;
    step();
    check1("rstb_en", mc_enable, 1'b0);
    check("rstb_addr", mc_addr, 32'h0);
    check("rstb_width", 32'(mc_width), 32'h0);
    check1("rstb_write", mc_write, 1'b0);
    check("rstb_if_data", if_data, 32'h0);
    check("rstb_ld_data", ld_data, 32'h0);
    rst = 1'b0; mc_ok = 1'b0; if_req = 1'b0;
    step(); step();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
